// File: rtl/irq_ctrl.sv
// Interrupt controller: four external sources (edge or level), one compare timer,
// pending/mask registers, a priority CLAIM port and an in-service handshake with CP0.
module irq_ctrl #(
  parameter int unsigned TIMER_W   = 32,
  parameter logic [3:0]  EDGE_MASK = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irqSrc,
  input  logic [4:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        intReq,
  input  logic        intAck,
  output logic        inService
);

  localparam logic [2:0] RegPending = 3'd0;
  localparam logic [2:0] RegMask    = 3'd1;
  localparam logic [2:0] RegCount   = 3'd2;
  localparam logic [2:0] RegCompare = 3'd3;
  localparam logic [2:0] RegCtrl    = 3'd4;
  localparam logic [2:0] RegClaim   = 3'd5;

  logic [4:0]         pending_q, pending_d;
  logic [4:0]         mask_q, mask_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] compare_q, compare_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [3:0]         src_prev_q;
  logic               armed_q;
  logic               in_service_q, in_service_d;

  logic [2:0] reg_sel;
  logic       claim_rd;
  logic [4:0] masked;
  logic [4:0] claim_onehot;
  logic       claim_valid;
  logic [2:0] claim_id;
  logic [3:0] src_rise;
  logic [3:0] src_set;
  logic       timer_hit;

  // Byte offset bits carry no meaning for word registers.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign reg_sel  = addr[4:2];
  assign claim_rd = re && (reg_sel == RegClaim);

  assign masked       = pending_q & mask_q;
  assign claim_valid  = |masked;
  // Isolate the lowest set bit: that is the source a CLAIM hands out.
  assign claim_onehot = masked & ~(masked - 5'd1);

  // Lowest-index masked pending source, encoded for the CLAIM word.
  always_comb begin
    claim_id = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (masked[i]) claim_id = 3'(i);
    end
  end

  // Edge detection is suppressed on the first cycle after reset so that a source
  // already high at release is not mistaken for a rising edge.
  assign src_rise  = irqSrc & ~src_prev_q & {4{armed_q}};
  assign src_set   = (EDGE_MASK & src_rise) | (~EDGE_MASK & irqSrc);
  assign timer_hit = ctrl_q[0] && (count_q == compare_q);

  // Next-state for all software-visible registers and the in-service flag.
  always_comb begin
    pending_d    = pending_q;
    mask_d       = mask_q;
    count_d      = count_q;
    compare_d    = compare_q;
    ctrl_d       = ctrl_q;
    in_service_d = in_service_q;

    // Clears first, then hardware set events, so a coincident set wins.
    if (we && (reg_sel == RegPending)) pending_d = pending_d & ~din[4:0];
    if (claim_rd) pending_d = pending_d & ~claim_onehot;
    pending_d = pending_d | {timer_hit, src_set};

    if (ctrl_q[0]) begin
      count_d = (timer_hit && ctrl_q[1]) ? '0 : count_q + TIMER_W'(1);
    end
    if (we && (reg_sel == RegCount))   count_d   = din[TIMER_W-1:0];
    if (we && (reg_sel == RegMask))    mask_d    = din[4:0];
    if (we && (reg_sel == RegCompare)) compare_d = din[TIMER_W-1:0];
    if (we && (reg_sel == RegCtrl))    ctrl_d    = din[1:0];

    if (intAck)   in_service_d = 1'b1;
    if (claim_rd) in_service_d = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q    <= '0;
      mask_q       <= '0;
      count_q      <= '0;
      compare_q    <= '0;
      ctrl_q       <= '0;
      src_prev_q   <= '0;
      armed_q      <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      ctrl_q       <= ctrl_d;
      src_prev_q   <= irqSrc;
      armed_q      <= 1'b1;
      in_service_q <= in_service_d;
    end
  end

  // Read mux; reflects register state before any write on the same edge.
  always_comb begin
    dout = 32'd0;
    case (reg_sel)
      RegPending: dout = {27'd0, pending_q};
      RegMask:    dout = {27'd0, mask_q};
      RegCount:   dout = 32'(count_q);
      RegCompare: dout = 32'(compare_q);
      RegCtrl:    dout = {30'd0, ctrl_q};
      RegClaim:   dout = claim_valid ? {1'b1, 28'd0, claim_id} : 32'd0;
      default:    dout = 32'd0;
    endcase
  end

  assign intReq    = claim_valid & ~in_service_q;
  assign inService = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a driver issues directed and random cycles and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_irq_ctrl;

  localparam int unsigned TW   = 8;
  localparam int unsigned MOD  = 1 << TW;
  localparam logic [3:0]  EDGE = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irqSrc = '0;
  logic [4:0]  addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        intReq;
  logic        intAck = 1'b0;
  logic        inService;

  irq_ctrl #(
    .TIMER_W   (TW),
    .EDGE_MASK (EDGE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irqSrc    (irqSrc),
    .addr      (addr),
    .re        (re),
    .we        (we),
    .din       (din),
    .dout      (dout),
    .intReq    (intReq),
    .intAck    (intAck),
    .inService (inService)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d;
    bit          irq;
    bit          svc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state, as seen by software.
  logic [4:0]  m_pend, m_mask;
  int unsigned m_count, m_cmp;
  logic [1:0]  m_ctrl;
  logic [3:0]  m_prev;
  bit          m_armed, m_svc;
  logic [3:0]  src_v;

  function automatic logic [31:0] m_claim();
    for (int i = 0; i < 5; i++) begin
      if (m_pend[i] && m_mask[i]) return 32'h8000_0000 | 32'(i);
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    case (int'(a[4:2]))
      0:       return {27'd0, m_pend};
      1:       return {27'd0, m_mask};
      2:       return 32'(m_count);
      3:       return 32'(m_cmp);
      4:       return {30'd0, m_ctrl};
      5:       return m_claim();
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_irq();
    return ((m_pend & m_mask) != 5'd0) && !m_svc;
  endfunction

  task automatic model_step(input logic [3:0] s, input logic [4:0] a, input bit r, input bit w,
                            input logic [31:0] d, input bit ack, input bit rs);
    int          sel;
    logic [31:0] cl;
    logic [4:0]  np;
    bit          hit;
    if (!rs) begin
      m_pend = '0; m_mask = '0; m_count = 0; m_cmp = 0; m_ctrl = '0;
      m_prev = '0; m_armed = 0; m_svc = 0;
      return;
    end
    sel = int'(a[4:2]);
    cl  = m_claim();
    hit = m_ctrl[0] && (m_count == m_cmp);
    np  = m_pend;
    if (w && sel == 0) np = np & ~d[4:0];
    if (r && sel == 5 && cl[31]) np[cl[2:0]] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (EDGE[i] ? (m_armed && s[i] && !m_prev[i]) : s[i]) np[i] = 1'b1;
    end
    if (hit) np[4] = 1'b1;
    if (w && sel == 2) m_count = d % MOD;
    else if (m_ctrl[0]) m_count = (hit && m_ctrl[1]) ? 0 : (m_count + 1) % MOD;
    if (w && sel == 1) m_mask = d[4:0];
    if (w && sel == 3) m_cmp = d % MOD;
    if (w && sel == 4) m_ctrl = d[1:0];
    if (ack) m_svc = 1;
    if (r && sel == 5) m_svc = 0;
    m_pend  = np;
    m_prev  = s;
    m_armed = 1;
  endtask

  // One bus cycle: drive inputs, queue the expectation, advance the model at the edge.
  task automatic step(input logic [4:0] a, input bit r, input bit w, input logic [31:0] d,
                      input bit ack, input bit rs, input bit use_c, input logic [31:0] cval,
                      input string nm);
    exp_t e;
    irqSrc = src_v; addr = a; re = r; we = w; din = d; intAck = ack; rst = rs;
    e.name = nm;
    e.d    = use_c ? cval : m_dout(a);
    e.irq  = m_irq();
    e.svc  = m_svc;
    sbq.push_back(e);
    @(posedge clk);
    model_step(src_v, a, r, w, d, ack, rs);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(a, 0, 1, d, 0, 1, 0, 0, "write");
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
    step(a, 0, 0, 0, 0, 1, 1, v, nm);
  endtask
  task automatic rdm(input logic [4:0] a, input string nm);
    step(a, 0, 0, 0, 0, 1, 0, 0, nm);
  endtask
  task automatic clm(input logic [31:0] v, input string nm);
    step(5'h14, 1, 0, 0, 0, 1, 1, v, nm);
  endtask
  task automatic rst_cyc();
    step(5'h00, 0, 0, 0, 0, 0, 0, 0, "reset");
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, ".dout"}, dout, mon_e.d);
        chk({mon_e.name, ".intReq"}, 32'(intReq), 32'(mon_e.irq));
        chk({mon_e.name, ".inService"}, 32'(inService), 32'(mon_e.svc));
      end
    end
  end

  initial begin
    src_v = '0;
    repeat (2) @(posedge clk);
    model_step('0, '0, 0, 0, '0, 0, 0);
    #1;

    // Edge source pulse, claim, pending cleared.
    rst_cyc();
    wr(5'h04, 32'h01);
    src_v = 4'b0001; rdm(5'h00, "p032_pre");
    src_v = 4'b0000; rd(5'h00, 32'h01, "p032_pend");
    clm(32'h8000_0000, "p032_claim");
    rd(5'h00, 32'h00, "p032_after");

    // Auto-reload timer.
    rst_cyc();
    wr(5'h0C, 32'd5);
    wr(5'h04, 32'h10);
    wr(5'h10, 32'h3);
    for (int k = 0; k < 7; k++) rd(5'h08, (k == 6) ? 32'd0 : 32'(k), "p033_count");
    clm(32'h8000_0004, "p033_claim");
    for (int k = 0; k < 6; k++) rdm(5'h00, "p033_period");
    wr(5'h10, 32'h0);

    // Priority order of successive claims.
    rst_cyc();
    wr(5'h04, 32'h0A);
    src_v = 4'b1010; rdm(5'h00, "p034_set");
    src_v = 4'b0000; rd(5'h00, 32'h0A, "p034_pend");
    clm(32'h8000_0001, "p034_claim1");
    clm(32'h8000_0003, "p034_claim2");
    clm(32'h0000_0000, "p034_claim3");

    // In-service handshake.
    rst_cyc();
    wr(5'h04, 32'h03);
    src_v = 4'b0011; rdm(5'h00, "p035_set");
    src_v = 4'b0000; step(5'h00, 0, 0, 0, 1, 1, 0, 0, "p035_ack");
    step(5'h00, 0, 0, 0, 1, 1, 1, 32'h03, "p035_ack_again");
    clm(32'h8000_0000, "p035_claim");
    rd(5'h00, 32'h02, "p035_resume");

    // Set beats write-1-to-clear.
    rst_cyc();
    rdm(5'h00, "p036_idle");
    src_v = 4'b0001; step(5'h00, 0, 1, 32'h01, 0, 1, 0, 0, "p036_w1c");
    src_v = 4'b0000; rd(5'h00, 32'h01, "p036_pend");

    // Source already high at reset release is not an edge.
    src_v = 4'b0001; rst_cyc();
    rd(5'h00, 32'h00, "p031_first");
    rd(5'h00, 32'h00, "p031_held");
    src_v = 4'b0000; rdm(5'h00, "p031_low");
    src_v = 4'b0001; rdm(5'h00, "p031_rise");
    src_v = 4'b0000; rd(5'h00, 32'h01, "p031_seen");

    // Timer wrap and write-wins on COUNT.
    rst_cyc();
    wr(5'h0C, 32'h80);
    wr(5'h08, 32'hFE);
    wr(5'h10, 32'h1);
    rd(5'h08, 32'hFE, "wrap_fe");
    rd(5'h08, 32'hFF, "wrap_ff");
    rd(5'h08, 32'h00, "wrap_00");
    wr(5'h08, 32'h1FF);
    rd(5'h08, 32'hFF, "count_write");
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h18, 32'h1F);
    rd(5'h18, 32'h0, "reg6");
    rd(5'h1C, 32'h0, "reg7");
    wr(5'h10, 32'h0);

    // Reset while everything is pending and in service.
    rst_cyc();
    wr(5'h04, 32'h1F);
    wr(5'h10, 32'h1);
    src_v = 4'b1111; rdm(5'h00, "p037_fill");
    src_v = 4'b0100; step(5'h00, 0, 0, 0, 1, 1, 1, 32'h1F, "p037_full");
    step(5'h00, 0, 0, 0, 0, 0, 0, 0, "p037_rst");
    rd(5'h00, 32'h00, "p037_cleared");
    rd(5'h00, 32'h04, "p037_level");
    rd(5'h04, 32'h00, "p037_mask");
    rd(5'h10, 32'h00, "p037_ctrl");

    // Randomized traffic.
    src_v = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] d;
      if ($urandom_range(3) == 0) src_v = 4'($urandom);
      d = $urandom;
      if ($urandom_range(7) == 0) d = d & 32'hFF;
      step(5'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0), d,
           ($urandom_range(7) == 0), ($urandom_range(99) != 0), 0, 0, "rand");
    end

    for (int i = 0; i < 10; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter TIMER_W, default 32, width of the timer count and compare registers.
REQ-002 Parameter EDGE_MASK, default 4'b1111, per external source: 1 = rising-edge triggered, 0 = level triggered.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-005 irqSrc  input  4  external interrupt sources, synchronous to clk.
REQ-006 addr  input  5  byte address of the register; [4:2] selects the register, [1:0] ignored.
REQ-007 re  input  1  read strobe, one cycle per access.
REQ-008 we  input  1  write strobe, one cycle per access.
REQ-009 din  input  32  write data.
REQ-010 dout  output  32  read data, combinational from addr.
REQ-011 intReq  output  1  level interrupt request toward CP0 (hardware interrupt line).
REQ-012 intAck  input  1  one-cycle pulse from CP0 when an interrupt exception is taken.
REQ-013 inService  output  1  high from intAck until the next CLAIM read.

Function
REQ-014 Register map ([4:2]):
- 0 PENDING: bits [4:0], read; write-1-to-clear.
- 1 MASK: bits [4:0], read/write.
- 2 COUNT: read/write.
- 3 COMPARE: read/write.
- 4 CTRL: bit0 timer enable, bit1 auto-reload.
- 5 CLAIM: read only, with a side effect.
- 6 and 7 read 0; writes to them are ignored.
REQ-015 Edge source i (EDGE_MASK[i]=1): PENDING[i] is set in the cycle after irqSrc[i] goes 0->1, using a registered copy of the previous value.
REQ-016 Level source i: PENDING[i] is set every cycle that irqSrc[i]=1.
REQ-017 Timer: when CTRL[0]=1, COUNT increments by 1 per cycle, modulo 2^TIMER_W.
REQ-018 When CTRL[0]=1 and COUNT==COMPARE, PENDING[4] is set at the next edge.
- CTRL[1]=1: COUNT loads 0.
- CTRL[1]=0: COUNT increments, wrapping.
REQ-019 intReq = |(PENDING & MASK) & ~inService, combinational from registers.
REQ-020 CLAIM read: dout = {valid, 28'b0, id[2:0]}.
- id is the lowest-index set bit of PENDING & MASK; valid = 1 if any such bit is set.
- If none is set, dout = 0.
REQ-021 On the clock edge with re=1 and addr=CLAIM:
- the claimed PENDING bit is cleared if valid;
- inService is cleared in all cases.
REQ-022 intAck=1 sets inService at the next edge; intAck while inService=1 has no further effect.
REQ-023 Write to PENDING in the same cycle as a set event on the same bit: the set wins.
REQ-024 Write to COUNT in the same cycle as an increment or reload: the written value wins; compare is checked against the pre-write value.
REQ-025 Write to MASK affects intReq from the following cycle.
REQ-026 re and we together: the write takes effect; dout shows the pre-write value; the CLAIM side effect still applies.
REQ-027 Write with addr=CLAIM has no effect.
REQ-028 Reads of PENDING, MASK, COUNT, COMPARE and CTRL have no side effects.

Reset
REQ-029 With rst=0 at a clock edge, the following are all 0 after that edge:
- PENDING, MASK, COUNT, COMPARE, CTRL;
- the edge-detect history;
- inService.
REQ-030 Reset mid-operation discards pending and in-service state; intReq=0 from the cycle after reset.
REQ-031 The first rising edge of irqSrc after reset release is detected only if the source was 0 at the first post-reset edge.

Verification
REQ-032 MASK=0x01; pulse irqSrc[0] for 1 cycle -> PENDING=0x01 next cycle, intReq=1; CLAIM read returns 0x80000000; PENDING=0 afterwards.
REQ-033 COMPARE=5, CTRL=0x3 -> PENDING[4] set once every 6 cycles; COUNT sequence 0..5,0; with MASK=0x10, CLAIM returns 0x80000004.
REQ-034 PENDING=0x0A with MASK=0x0A -> CLAIM returns 0x80000001; a second CLAIM returns 0x80000003; a third returns 0x00000000.
REQ-035 intAck pulse with intReq=1 -> intReq=0 and inService=1 until a CLAIM read; then intReq=1 again if other masked bits remain pending.
REQ-036 Write PENDING=0x01 in the same cycle as a new edge on irqSrc[0] -> PENDING[0] remains 1.
REQ-037 rst=0 for 1 cycle while PENDING=0x1F and inService=1 -> all registers 0 and intReq=0; a level-high irqSrc[2] sets PENDING[2] one cycle after release.
